// File: rtl/vip_bch_serial_encoder.sv
// Bit-serial systematic BCH encoder.
// Accepts one D-bit message word, then streams D message bits MSB-first
// followed by E parity bits MSB-first. Parity comes from a generator-polynomial
// LFSR that divides m(x)*x^E by g(x) as the message bits go out.
module vip_bch_serial_encoder #(
    parameter int unsigned D        = 21,
    parameter int unsigned E        = 10,
    parameter int unsigned N        = 31,
    parameter logic [E:0]  GEN_POLY = 11'h769
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_last,
    output logic         out_parity,
    output logic         busy
);

    localparam int unsigned MaxDE = (D > E) ? D : E;
    localparam int unsigned CW    = $clog2(MaxDE + 1);

    // Reject unusable code parameters at elaboration time.
    if (D < 1 || E < 1 || D + E > N) begin : g_bad_len
        $error("vip_bch_serial_encoder: need 1 <= D and D+E <= N");
    end
    if (GEN_POLY[E] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
        $error("vip_bch_serial_encoder: GEN_POLY must have bit E and bit 0 set");
    end

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity
    } state_e;

    state_e          state_q;
    logic [D-1:0]    shift_q;
    logic [E-1:0]    lfsr_q;
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_parity_q;
    logic            out_last_q;
    logic            busy_q;

    logic            lfsr_fb_d;
    logic [E-1:0]    lfsr_data_d;
    logic [E-1:0]    lfsr_par_d;
    logic [CW-1:0]   cnt_inc_d;

    // Current codeword bit: message MSB in DATA, remainder MSB in PARITY.
    always_comb begin
        out_bit = 1'b0;
        if (out_valid_q) begin
            out_bit = out_parity_q ? lfsr_q[E-1] : shift_q[D-1];
        end
    end

    // LFSR next values: divide-by-g(x) step for data, plain shift-out for parity.
    always_comb begin
        lfsr_fb_d   = shift_q[D-1] ^ lfsr_q[E-1];
        lfsr_data_d = (lfsr_q << 1) ^ (lfsr_fb_d ? GEN_POLY[E-1:0] : '0);
        lfsr_par_d  = lfsr_q << 1;
        cnt_inc_d   = cnt_q + CW'(1);
    end

    // Sequencing FSM; all handshake/status outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            lfsr_q       <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_parity_q <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        shift_q      <= in_data;
                        lfsr_q       <= '0;
                        cnt_q        <= '0;
                        in_ready_q   <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_parity_q <= 1'b0;
                        out_last_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StData;
                    end
                end
                StData: begin
                    if (out_ready) begin
                        lfsr_q  <= lfsr_data_d;
                        shift_q <= shift_q << 1;
                        if (cnt_q == CW'(D - 1)) begin
                            cnt_q        <= '0;
                            out_parity_q <= 1'b1;
                            out_last_q   <= (E == 1);
                            state_q      <= StParity;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                end
                StParity: begin
                    if (out_ready) begin
                        lfsr_q <= lfsr_par_d;
                        if (cnt_q == CW'(E - 1)) begin
                            cnt_q        <= '0;
                            in_ready_q   <= 1'b1;
                            out_valid_q  <= 1'b0;
                            out_parity_q <= 1'b0;
                            out_last_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= StIdle;
                        end else begin
                            cnt_q      <= cnt_inc_d;
                            out_last_q <= (cnt_inc_d == CW'(E - 1));
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vip_bch_serial_encoder.sv
// Self-checking bench for vip_bch_serial_encoder using a bit-level scoreboard
// fed by a long-division reference model.
module tb_vip_bch_serial_encoder;

    localparam int unsigned D = 21;
    localparam int unsigned E = 10;
    localparam int unsigned N = 31;
    localparam int unsigned C = D + E;
    localparam logic [E:0] GEN = 11'h769;
    localparam int NSTORE = 200;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic         out_parity;
    logic         busy;

    typedef struct packed {
        logic b;
        logic p;
        logic l;
    } exp_t;

    exp_t exp_q[$];
    int n_tests;
    int n_fail;
    int cyc;
    logic [D-1:0] words [NSTORE];
    logic [C-1:0] cws   [NSTORE];

    vip_bch_serial_encoder #(
        .D        (D),
        .E        (E),
        .N        (N),
        .GEN_POLY (GEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last),
        .out_parity (out_parity),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Remainder of m(x)*x^E divided by g(x), by polynomial long division.
    function automatic logic [E-1:0] ref_parity(input logic [D-1:0] m);
        logic [63:0] v;
        v = 64'(m) << E;
        for (int i = C - 1; i >= int'(E); i--) begin
            if (v[i]) v = v ^ (64'(GEN) << (i - E));
        end
        return v[E-1:0];
    endfunction

    // Remainder of a full codeword c(x) divided by g(x); zero for a valid codeword.
    function automatic logic [E-1:0] cw_syndrome(input logic [C-1:0] cw);
        logic [63:0] v;
        v = 64'(cw);
        for (int i = C - 1; i >= int'(E); i--) begin
            if (v[i]) v = v ^ (64'(GEN) << (i - E));
        end
        return v[E-1:0];
    endfunction

    function automatic void push_expected(input logic [D-1:0] m);
        logic [E-1:0] p;
        exp_t e;
        p = ref_parity(m);
        for (int i = D - 1; i >= 0; i--) begin
            e.b = m[i]; e.p = 1'b0; e.l = 1'b0;
            exp_q.push_back(e);
        end
        for (int j = E - 1; j >= 0; j--) begin
            e.b = p[j]; e.p = 1'b1; e.l = (j == 0);
            exp_q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word, stream its codeword with out_ready at duty percent, score every beat.
    task automatic encode_word(input logic [D-1:0] m, input int duty, input bit hold,
                               output logic [C-1:0] cw, output int acc_cyc);
        int guard;
        int beats;
        bit stalled;
        logic pb, pp, pl;
        exp_t e;
        cw = '0;
        acc_cyc = 0;
        pb = 1'b0; pp = 1'b0; pl = 1'b0;
        in_data  = m;
        in_valid = 1'b1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        push_expected(m);
        tick();
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
        beats = 0;
        guard = 0;
        stalled = 1'b0;
        while (beats < int'(C) && guard < 5000) begin
            n_tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_flags beat %0d: valid/busy/in_ready=%b%b%b required 110",
                         beats, out_valid, busy, in_ready);
            end
            if (stalled) begin
                n_tests++;
                if ({out_bit, out_parity, out_last} !== {pb, pp, pl}) begin
                    n_fail++;
                    $display("FAIL stall_hold beat %0d: bit/par/last=%b%b%b required %b%b%b",
                             beats, out_bit, out_parity, out_last, pb, pp, pl);
                end
            end
            out_ready = ($urandom_range(99) < duty);
            if (out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty beat %0d: queue size 0 required >0", beats);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_bit, out_parity, out_last} !== {e.b, e.p, e.l}) begin
                        n_fail++;
                        $display("FAIL beat %0d word %h: bit/par/last=%b%b%b required %b%b%b",
                                 beats, m, out_bit, out_parity, out_last, e.b, e.p, e.l);
                    end
                end
                cw = {cw[C-2:0], out_bit};
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pb = out_bit; pp = out_parity; pl = out_last;
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (beats < int'(C)) begin
            n_fail++;
            $display("FAIL beat_timeout: beats=%0d required %0d", beats, C);
        end
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_return: in_ready/valid/busy=%b%b%b required 100",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if ({in_ready, out_valid, out_bit, out_last, out_parity, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL %s: rdy/vld/bit/last/par/busy=%b%b%b%b%b%b required 100000", tag,
                     in_ready, out_valid, out_bit, out_last, out_parity, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #2;
        check_reset_values("reset_async");
        tick(); tick();
        check_reset_values("reset_held");
        rst = 1'b0;
        tick();
        check_reset_values("reset_release");
    endtask

    task automatic test_zero_word();
        logic [C-1:0] cw;
        int a;
        encode_word('0, 100, 1'b0, cw, a);
        n_tests++;
        if (cw !== '0) begin
            n_fail++;
            $display("FAIL zero_word: cw=%h required 0", cw);
        end
    endtask

    task automatic test_unit_word();
        logic [C-1:0] cw;
        logic [C-1:0] req;
        int a;
        req = {21'h000001, 10'h369};
        encode_word(21'h000001, 100, 1'b0, cw, a);
        n_tests++;
        if (cw !== req) begin
            n_fail++;
            $display("FAIL unit_word: cw=%h required %h", cw, req);
        end
    endtask

    task automatic test_random_words();
        logic [C-1:0] cw;
        logic [D-1:0] m;
        int a;
        for (int i = 0; i < 1001; i++) begin
            m = (i == 0) ? 21'h100000 : D'($urandom);
            encode_word(m, 100, 1'b0, cw, a);
            n_tests++;
            if (cw_syndrome(cw) !== '0 || cw[C-1 -: D] !== m) begin
                n_fail++;
                $display("FAIL divisible word %h: cw=%h syndrome=%h required 0", m, cw,
                         cw_syndrome(cw));
            end
            if (i < NSTORE) begin
                words[i] = m;
                cws[i] = cw;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [C-1:0] cw;
        int a;
        for (int i = 0; i < NSTORE; i++) begin
            encode_word(words[i], 30, 1'b0, cw, a);
            n_tests++;
            if (cw !== cws[i]) begin
                n_fail++;
                $display("FAIL backpressure word %h: cw=%h required %h", words[i], cw, cws[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [C-1:0] cw;
        int a;
        int prev;
        logic [D-1:0] m;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            m = D'($urandom);
            encode_word(m, 100, 1'b1, cw, a);
            if (prev >= 0) begin
                n_tests++;
                if (a - prev != int'(C) + 1) begin
                    n_fail++;
                    $display("FAIL b2b_gap: accept spacing=%0d required %0d", a - prev, C + 1);
                end
            end
            n_tests++;
            if (cw_syndrome(cw) !== '0) begin
                n_fail++;
                $display("FAIL b2b_divisible: cw=%h syndrome nonzero", cw);
            end
            prev = a;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        logic [C-1:0] cw;
        logic [C-1:0] req;
        int a;
        req = {21'h000001, 10'h369};
        in_data = 21'h155555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        out_ready = 1'b0;
        tick();
        check_reset_values("mid_reset_held");
        rst = 1'b0;
        tick();
        encode_word(21'h000001, 100, 1'b0, cw, a);
        n_tests++;
        if (cw !== req) begin
            n_fail++;
            $display("FAIL after_reset_word: cw=%h required %h", cw, req);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        test_reset();
        test_zero_word();
        test_unit_word();
        test_random_words();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
